// File: rtl/usb_desc_pkg.sv
// Shared constants and types for the endpoint-0 descriptor reader.
package usb_desc_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned TYPE_W = 2;

  // Descriptor placement in the descriptor ROM
  localparam logic [ADDR_W-1:0] DEV_BASE = 6'd1;
  localparam logic [LEN_W-1:0]  DEV_SIZE = 8'd18;
  localparam logic [ADDR_W-1:0] CFG_BASE = 6'd19;
  localparam logic [LEN_W-1:0]  CFG_SIZE = 8'd25;
  localparam logic [ADDR_W-1:0] STR_BASE = 6'd44;
  localparam logic [LEN_W-1:0]  STR_SIZE = 8'd3;

  typedef enum logic [TYPE_W-1:0] {
    REQ_DEVICE  = 2'd0,
    REQ_CONFIG  = 2'd1,
    REQ_STRING  = 2'd2,
    REQ_ILLEGAL = 2'd3
  } req_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // One sub-descriptor: inclusive address range and its bLength
  typedef struct packed {
    logic [ADDR_W-1:0] first;
    logic [ADDR_W-1:0] last;
    logic [LEN_W-1:0]  blen;
  } subdesc_t;

  localparam int unsigned N_SUBDESC = 5;

  // Device, config, interface, endpoint (config set spans three entries), string
  localparam subdesc_t SUBDESC_TAB [N_SUBDESC] = '{
    '{6'd1,  6'd18, 8'd18},
    '{6'd19, 6'd27, 8'd9},
    '{6'd28, 6'd36, 8'd9},
    '{6'd37, 6'd43, 8'd7},
    '{6'd44, 6'd46, 8'd3}
  };

  // First ROM address of the descriptor selected by a request
  function automatic logic [ADDR_W-1:0] req_base(input req_type_e t);
    logic [ADDR_W-1:0] b;
    case (t)
      REQ_DEVICE: b = DEV_BASE;
      REQ_CONFIG: b = CFG_BASE;
      REQ_STRING: b = STR_BASE;
      default:    b = '0;
    endcase
    return b;
  endfunction

  // Total byte size of the descriptor selected by a request
  function automatic logic [LEN_W-1:0] req_size(input req_type_e t);
    logic [LEN_W-1:0] s;
    case (t)
      REQ_DEVICE: s = DEV_SIZE;
      REQ_CONFIG: s = CFG_SIZE;
      REQ_STRING: s = STR_SIZE;
      default:    s = '0;
    endcase
    return s;
  endfunction

  // Host may ask for less than the full descriptor, never more
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] want,
                                                 input logic [LEN_W-1:0] size);
    return (want < size) ? want : size;
  endfunction

endpackage

// File: rtl/descriptor_reader_if.sv
// Request, ROM and byte-stream signals of the descriptor reader.
interface descriptor_reader_if;
  import usb_desc_pkg::*;

  logic                  reqValid;
  logic [TYPE_W-1:0]     reqType;
  logic [LEN_W-1:0]      reqLength;
  logic                  romCheckData;
  logic [ADDR_W-1:0]     romAddr;
  logic [LEN_W-1:0]      romLengthDesc;
  logic [DATA_W-1:0]     romData;
  logic [DATA_W-1:0]     outData;
  logic                  outValid;
  logic                  outReady;
  logic                  outLast;
  logic                  xferDone;
  logic                  reqErr;
  logic                  busy;

  // Engine side
  modport master (
    input  reqValid, reqType, reqLength, romData, outReady,
    output romCheckData, romAddr, romLengthDesc, outData, outValid, outLast,
           xferDone, reqErr, busy
  );

  // Environment side: SETUP decoder, ROM and packetizer
  modport slave (
    output reqValid, reqType, reqLength, romData, outReady,
    input  romCheckData, romAddr, romLengthDesc, outData, outValid, outLast,
           xferDone, reqErr, busy
  );

endinterface

// File: rtl/desc_len_lut.sv
// Maps a ROM address to the bLength of the sub-descriptor containing it.
module desc_len_lut
  import usb_desc_pkg::*;
(
  input  logic [ADDR_W-1:0] addr_i,
  output logic [LEN_W-1:0]  blen_c
);

  // Range match against the sub-descriptor table; unmapped addresses give 0
  always_comb begin
    blen_c = '0;
    for (int unsigned i = 0; i < N_SUBDESC; i++) begin
      if (addr_i >= SUBDESC_TAB[i].first && addr_i <= SUBDESC_TAB[i].last) begin
        blen_c = SUBDESC_TAB[i].blen;
      end
    end
  end

endmodule

// File: rtl/descriptor_reader.sv
// Endpoint-0 descriptor reader: walks a descriptor in ROM and streams it
// byte by byte to the packetizer, marking packet boundaries with outLast.
module descriptor_reader
  import usb_desc_pkg::*;
#(
  parameter int unsigned MAX_PKT = 8
) (
  input logic               useClk,
  input logic               nReset,
  descriptor_reader_if.master bus
);

  localparam int unsigned     PKT_W    = (MAX_PKT > 1) ? $clog2(MAX_PKT) : 1;
  localparam logic [PKT_W-1:0] PKT_LAST = PKT_W'(MAX_PKT - 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q,  addr_d;
  logic [LEN_W-1:0]   rem_q,   rem_d;
  logic [PKT_W-1:0]   pkt_q,   pkt_d;
  logic               check_q, check_d;
  logic               valid_q, valid_d;
  logic               last_q,  last_d;
  logic               done_q,  done_d;
  logic               err_q,   err_d;
  logic               busy_q,  busy_d;

  req_type_e          req_type_c;
  logic [LEN_W-1:0]   req_len_c;
  logic               hs_c;

  assign req_type_c = req_type_e'(bus.reqType);
  assign req_len_c  = clamp_len(bus.reqLength, req_size(req_type_c));
  assign hs_c       = valid_q && bus.outReady;

  // Next state, counters and next values of the registered outputs
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    pkt_d   = pkt_q;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.reqValid) begin
          if (req_type_c == REQ_ILLEGAL) begin
            err_d = 1'b1;
          end else begin
            addr_d  = req_base(req_type_c);
            rem_d   = req_len_c;
            pkt_d   = '0;
            state_d = (req_len_c == '0) ? ST_DONE : ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (hs_c) begin
          rem_d   = LEN_W'(rem_q - 1'b1);
          pkt_d   = (pkt_q == PKT_LAST) ? '0 : PKT_W'(pkt_q + 1'b1);
          addr_d  = ADDR_W'(addr_q + 1'b1);
          state_d = (rem_q == LEN_W'(1)) ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs follow the state being entered so they line up with it
    check_d = (state_d == ST_FETCH);
    valid_d = (state_d == ST_SEND);
    last_d  = valid_d && ((pkt_d == PKT_LAST) || (rem_d == LEN_W'(1)));
    done_d  = (state_d == ST_DONE);
    busy_d  = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge useClk or negedge nReset) begin
    if (!nReset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      pkt_q   <= '0;
      check_q <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      pkt_q   <= pkt_d;
      check_q <= check_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // bLength of the sub-descriptor currently addressed
  desc_len_lut u_len_lut (
    .addr_i (addr_q),
    .blen_c (bus.romLengthDesc)
  );

  assign bus.romCheckData = check_q;
  assign bus.romAddr      = addr_q;
  // ROM output is already registered and holds between fetches; gate to 0 when idle
  assign bus.outData      = valid_q ? bus.romData : '0;
  assign bus.outValid     = valid_q;
  assign bus.outLast      = last_q;
  assign bus.xferDone     = done_q;
  assign bus.reqErr       = err_q;
  assign bus.busy         = busy_q;

endmodule
